// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8N1 UART receiver with 16x oversampling and valid/ack holding register
//
// Purpose: synchronises the asynchronous RX line, validates the start bit, samples each bit at
// its midpoint and hands complete bytes to the consumer through a one-entry holding register.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit (PARITY_ODD selects odd parity)
// and the rxParityErrOUT pulse output.
//
// Ports:
//   clockIN        in   system clock, posedge
//   nResetIN       in   asynchronous active-low reset
//   rxIN           in   serial line, idle high, asynchronous
//   rxAckIN        in   consumer accepts rxDataOUT
//   rxDataOUT      out  last received byte
//   rxValidOUT     out  byte waiting for the consumer
//   rxBusyOUT      out  receiver is inside a frame
//   rxFrameErrOUT  out  one-cycle pulse, stop bit sampled low
//   rxOverrunOUT   out  sticky, a byte was overwritten before being acked
//   rxParityErrOUT out  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_oversampled #(
    parameter int CLOCK_FREQUENCY = 10_000_000,
    parameter int BAUD_RATE       = 115200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD      = 1'b0
`endif
) (
    input  logic       clockIN,
    input  logic       nResetIN,
    input  logic       rxIN,
    input  logic       rxAckIN,
    output logic [7:0] rxDataOUT,
    output logic       rxValidOUT,
    output logic       rxBusyOUT,
    output logic       rxFrameErrOUT,
    output logic       rxOverrunOUT
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rxParityErrOUT
`endif
);

    localparam int OS_DIV = CLOCK_FREQUENCY / (BAUD_RATE * 16);
    localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(OS_DIV - 1);
    // The edge-detect cycle already counts as the first clock of the first tick period.
    localparam logic [DIV_W-1:0] DIV_RESTART = DIV_W'((OS_DIV > 1) ? 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_e;

    state_e           state_q;
    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       os_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q;
    logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_q;
`endif

    logic rx_s, rx_fall, tick, sample_half, sample_full, byte_done;

    always_comb begin
        rx_s        = sync_q[1];
        rx_fall     = rx_prev_q & ~rx_s;
        tick        = (state_q != S_IDLE) && (div_q == DIV_LAST);
        sample_half = tick && (os_q == 4'd7);
        sample_full = tick && (os_q == 4'd15);
        byte_done   = (state_q == S_STOP) && sample_full && rx_s;
        data_d      = byte_done ? shift_q : data_q;
        // Completion wins over a same-cycle ack; overrun only when the old byte was never taken.
        valid_d     = byte_done | (valid_q & ~rxAckIN);
        overrun_d   = (overrun_q | (byte_done & valid_q)) & ~(rxAckIN & valid_q);
    end

    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            os_q         <= 4'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rxIN};
            rx_prev_q   <= rx_s;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (state_q == S_IDLE || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (tick) begin
                os_q <= os_q + 4'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        div_q   <= DIV_RESTART;
                        os_q    <= 4'd0;
                    end
                end
                S_START: begin
                    if (sample_half) begin
                        // Re-align so later samples land 16 ticks apart at bit midpoints.
                        os_q <= 4'd0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                            bit_q   <= 3'd0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_full) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_full) begin
                        if (((^shift_q) ^ rx_s) != PARITY_ODD) begin
                            parity_err_q <= 1'b1;
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (sample_full) begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Hold off until the line idles so a stuck-low line cannot retrigger.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rxDataOUT     = data_q;
    assign rxValidOUT    = valid_q;
    assign rxBusyOUT     = busy_q;
    assign rxFrameErrOUT = frame_err_q;
    assign rxOverrunOUT  = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rxParityErrOUT = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

    localparam int CLK_HZ   = 3_686_400;
    localparam int BAUD     = 115200;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Two synchroniser clocks plus the distance from frame start to the stop-bit midpoint.
    localparam int DONE_CLKS = 2 + FRAME_BITS * BIT_CLKS - BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, rx_ferr, rx_ovr;
`ifdef UART_RX_PARITY_EN
    logic       rx_perr;
`endif

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;

    uart_rx_oversampled #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE(BAUD)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(1'b0)
`endif
    ) dut (
        .clockIN(clk),
        .nResetIN(rst_n),
        .rxIN(rx),
        .rxAckIN(ack),
        .rxDataOUT(rx_data),
        .rxValidOUT(rx_valid),
        .rxBusyOUT(rx_busy),
        .rxFrameErrOUT(rx_ferr),
        .rxOverrunOUT(rx_ovr)
`ifdef UART_RX_PARITY_EN
        ,
        .rxParityErrOUT(rx_perr)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ferr) fe_cnt++;
`ifdef UART_RX_PARITY_EN
        if (rx_perr) pe_cnt++;
`endif
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cycles(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
`endif
        drive_bit(stop_v);
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ^b;
    endfunction

    task automatic pulse_ack();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        checks++; if (rx_ferr !== 1'b0 || rx_ovr !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", rx_ferr, rx_ovr); end
    endtask

    task automatic test_single();
        int fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1, good_par(8'hA5));
            begin
                cycles(DONE_CLKS);
                checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL single_latency valid got=%b exp=1", rx_valid); end
            end
        join
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rx_data); end
        checks++; if (rx_ovr !== 1'b0 || fe_cnt != fe0) begin failures++; $display("FAIL single_flags ovr=%b fe=%0d exp ovr=0 fe=0", rx_ovr, fe_cnt - fe0); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_ack valid got=%b exp=0", rx_valid); end
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        rx = 1'b0;
        cycles(10);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b exp=1", rx_busy); end
        rx = 1'b1;
        cycles(40);
        checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_idle busy=%b valid=%b exp 0 0", rx_busy, rx_valid); end
        checks++; if (fe_cnt != fe0 || rx_ovr !== 1'b0) begin failures++; $display("FAIL glitch_flags fe=%0d ovr=%b exp 0 0", fe_cnt - fe0, rx_ovr); end
    endtask

    task automatic test_break();
        int fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        cycles(3 * BIT_CLKS);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", rx_busy); end
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL break_ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL break_valid got=%b exp=0", rx_valid); end
        rx = 1'b1;
        cycles(BIT_CLKS);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_release busy got=%b exp=0", rx_busy); end
        send_frame(8'h55, 1'b1, good_par(8'h55));
        checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin failures++; $display("FAIL break_next data=%h valid=%b exp 55 1", rx_data, rx_valid); end
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL break_next_ferr got=%0d exp=1", fe_cnt - fe0); end
        pulse_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h01, 1'b1, good_par(8'h01));
        send_frame(8'h02, 1'b1, good_par(8'h02));
        checks++; if (rx_data !== 8'h02 || rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_data data=%h valid=%b exp 02 1", rx_data, rx_valid); end
        checks++; if (rx_ovr !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", rx_ovr); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0 || rx_ovr !== 1'b0) begin failures++; $display("FAIL ovr_ack valid=%b ovr=%b exp 0 0", rx_valid, rx_ovr); end
    endtask

    task automatic test_ack_same_cycle();
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        fork
            send_frame(8'hC3, 1'b1, good_par(8'hC3));
            begin
                cycles(DONE_CLKS - 1);
                pulse_ack();
            end
        join
        checks++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin failures++; $display("FAIL same_cycle data=%h valid=%b exp c3 1", rx_data, rx_valid); end
        checks++; if (rx_ovr !== 1'b0) begin failures++; $display("FAIL same_cycle_ovr got=%b exp=0", rx_ovr); end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        send_frame(8'h9E, 1'b1, good_par(8'h9E));
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        cycles(BIT_CLKS / 2);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", rx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset data=%h valid=%b exp 00 0", rx_data, rx_valid); end
        checks++; if (rx_busy !== 1'b0 || rx_ovr !== 1'b0 || rx_ferr !== 1'b0) begin failures++; $display("FAIL mid_reset_flags busy=%b ovr=%b ferr=%b exp 0 0 0", rx_busy, rx_ovr, rx_ferr); end
        cycles(4);
        rst_n = 1'b1;
        cycles(5 * BIT_CLKS);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1 || rx_ovr !== 1'b0) begin failures++; $display("FAIL mid_next data=%h valid=%b ovr=%b exp 81 1 0", rx_data, rx_valid, rx_ovr); end
        pulse_ack();
    endtask

    task automatic test_random();
        logic       pending = 1'b0;
        logic       exp_ovr = 1'b0;
        logic [7:0] b;
        int         fe0 = fe_cnt;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, good_par(b));
            if (pending) exp_ovr = 1'b1;
            pending = 1'b1;
            checks++; if (rx_data !== b || rx_valid !== 1'b1) begin failures++; $display("FAIL rand_data[%0d] data=%h valid=%b exp %h 1", n, rx_data, rx_valid, b); end
            checks++; if (rx_ovr !== exp_ovr) begin failures++; $display("FAIL rand_ovr[%0d] got=%b exp=%b", n, rx_ovr, exp_ovr); end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                pending = 1'b0;
                exp_ovr = 1'b0;
                checks++; if (rx_valid !== 1'b0 || rx_ovr !== 1'b0) begin failures++; $display("FAIL rand_ack[%0d] valid=%b ovr=%b exp 0 0", n, rx_valid, rx_ovr); end
            end
            cycles($urandom_range(0, 40));
        end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL rand_ferr got=%0d exp=0", fe_cnt - fe0); end
        if (rx_valid) pulse_ack();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        checks++; if (pe_cnt - pe0 != 1 || rx_valid !== 1'b0) begin failures++; $display("FAIL parity_bad pulses=%0d valid=%b exp 1 0", pe_cnt - pe0, rx_valid); end
        cycles(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b1);
        checks++; if (rx_data !== 8'h07 || rx_valid !== 1'b1 || pe_cnt - pe0 != 1) begin failures++; $display("FAIL parity_good data=%h valid=%b pulses=%0d exp 07 1 1", rx_data, rx_valid, pe_cnt - pe0); end
        pulse_ack();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_overrun();
        test_ack_same_cycle();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
